acorn128_sequencer: RTL
=======================

// Module: acorn128_sequencer
// PURPOSE
//  Parametrised ACORN-128 phase sequencer; successor to the fixed-count top-level controller.
//  Drives per-cycle step enable, ca/cb control bits and input-source select to a
//  P-bit-per-cycle ACORN state core through INIT, AD, MSG and FINAL.
//  Supports runtime AD/message bit lengths, encrypt or decrypt mode and a
//  valid/ready data handshake. Supports abort; flags the 128 tag-producing steps.
// PARAMETERS
//  P      1   state steps per cycle; power of two, 1..128
//  LEN_W  64  bit-length field width (ad_len_in, msg_len_in, step counter)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, asynchronous, active-high
//  start_in        in   1      start request; sampled only in IDLE
//  abort_in        in   1      synchronous abort, any phase
//  decrypt_in      in   1      mode, latched at start (0 encrypt, 1 decrypt)
//  ad_len_in       in   LEN_W  AD length in bits, latched at start
//  msg_len_in      in   LEN_W  message length in bits, latched at start
//  data_valid_in   in   1      AD/message chunk (P bits) available
//  data_ready_out  out  1      sequencer consumes a chunk this cycle if valid
//  step_en_out     out  1      core advances P steps this cycle
//  src_sel_out     out  3      0 KEY, 1 IV, 2 KEY_FLIP, 3 DATA, 4 PAD1, 5 ZERO
//  key_idx_out     out  7      bit index (step mod 128) of first bit of chunk
//  ca_out          out  1      ACORN ca control bit
//  cb_out          out  1      ACORN cb control bit
//  decrypt_out     out  1      latched mode
//  phase_out       out  3      0 IDLE, 1 INIT, 2 AD, 3 MSG, 4 FINAL, 5 DONE
//  tag_cap_out     out  1      step_en chunk lies in FINAL steps 640..767
//  busy_out        out  1      phase != IDLE and != DONE
//  done_out        out  1      one-cycle pulse on entry to DONE
//  tag_ok_out      out  1      decrypt tag match (ACORN_TAG_CHECK_EN only)
// BEHAVIOUR
//  Reset: phase IDLE, every output 0, counters/latched lengths 0.
//  IDLE: start_in=1 -> latch lengths (low log2(P) bits dropped) and mode; INIT next cycle.
//  Step counter s counts in steps, +P per step_en; clears on each phase entry.
//  INIT: 1792 steps, step_en=1 every cycle, ca=cb=1. src: s<128 KEY, s<256 IV,
//   s==256 KEY_FLIP (chunk's first key bit inverted), else KEY; key_idx=s[6:0].
//  AD: data part s<ad_len: src DATA, data_ready=1, step_en=data_valid_in (stall
//   otherwise, s holds). Pad part: 256 steps, step_en=1, data_ready=0; first
//   chunk PAD1 (single 1 then zeros), rest ZERO. cb=1 throughout AD;
//   ca=1 for data part and pad steps 0..127, ca=0 for pad steps 128..255.
//  MSG: same structure with msg_len; cb=0 throughout; ca as AD.
//  FINAL: 768 steps, ZERO, ca=cb=1; tag_cap_out=step_en for s>=640.
//  Zero length: data part skipped, phase enters directly at pad step 0.
//  Transitions on the last step_en cycle of a phase; no idle cycle between phases.
//  DONE: done_out pulses 1 cycle, phase holds DONE; start_in -> new run (INIT next).
//  start_in ignored when busy. abort_in has priority over everything incl. start:
//   next cycle phase IDLE, all outputs 0, no done pulse.
//  Counter wrap impossible: lengths < 2^LEN_W-256 required; larger is undefined.
//  Step cycles = (1792+ad+256+msg+256+768)/P plus stall cycles.
// CONFIGURATION
//  ACORN_TAG_CHECK_EN defined: extra ports tag_in[127:0] (latched at start),
//   ks_in[P-1:0] (core keystream); during tag_cap steps ks chunks are compared
//   in step order with tag_in bits 0..127; tag_ok_out=1 at done pulse
//   iff decrypt and all 128 bits match, held until next start/abort/reset.
//  Undefined: no extra ports; tag_ok_out tied 0.
// TESTING
//  P=1, ad=0, msg=0, start 1 cycle -> 3072 step_en cycles, done_out at cycle 3073.
//  P=8, ad=128, msg=256, valid always 1 -> 432 step_en cycles, PAD1 exactly twice.
//  P=1, ad=64, valid toggled 1/0 -> 64 data_ready&valid transfers, s stalls on 0 cycles.
//  Abort in MSG at s=100 -> next cycle IDLE, all outputs 0; restart runs full sequence.
//  start_in held 1 during INIT -> no restart; s==256 shows KEY_FLIP exactly once.
//  ACORN_TAG_CHECK_EN, decrypt, ks==tag_in -> tag_ok_out=1; one bit flipped -> 0.

Source files
------------

// File: rtl/acorn128_sequencer.sv
// ACORN-128 phase sequencer: per-cycle step enable, ca/cb and source select through INIT/AD/MSG/FINAL.
// Define ACORN_TAG_CHECK_EN to add tag_in/ks_in and the decrypt tag comparison behind tag_ok_out.
module acorn128_sequencer #(
  parameter int unsigned P     = 1,
  parameter int unsigned LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic             decrypt_in,
  input  logic [LEN_W-1:0] ad_len_in,
  input  logic [LEN_W-1:0] msg_len_in,
  input  logic             data_valid_in,
`ifdef ACORN_TAG_CHECK_EN
  input  logic [127:0]     tag_in,
  input  logic [P-1:0]     ks_in,
`endif
  output logic             data_ready_out,
  output logic             step_en_out,
  output logic [2:0]       src_sel_out,
  output logic [6:0]       key_idx_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             decrypt_out,
  output logic [2:0]       phase_out,
  output logic             tag_cap_out,
  output logic             busy_out,
  output logic             done_out,
  output logic             tag_ok_out
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INIT  = 3'd1,
    PH_AD    = 3'd2,
    PH_MSG   = 3'd3,
    PH_FINAL = 3'd4,
    PH_DONE  = 3'd5
  } phase_t;

  typedef enum logic [2:0] {
    SRC_KEY      = 3'd0,
    SRC_IV       = 3'd1,
    SRC_KEY_FLIP = 3'd2,
    SRC_DATA     = 3'd3,
    SRC_PAD1     = 3'd4,
    SRC_ZERO     = 3'd5
  } src_t;

  localparam logic [LEN_W-1:0] STEP        = LEN_W'(P);
  localparam logic [LEN_W-1:0] LEN_MASK    = ~(STEP - LEN_W'(1));
  localparam logic [LEN_W-1:0] INIT_STEPS  = LEN_W'(1792);
  localparam logic [LEN_W-1:0] PAD_STEPS   = LEN_W'(256);
  localparam logic [LEN_W-1:0] FINAL_STEPS = LEN_W'(768);
  localparam logic [LEN_W-1:0] KEY_END     = LEN_W'(128);
  localparam logic [LEN_W-1:0] IV_END      = LEN_W'(256);
  localparam logic [LEN_W-1:0] PAD_CA_END  = LEN_W'(128);
  localparam logic [LEN_W-1:0] TAG_FIRST   = LEN_W'(640);

  phase_t           phase;
  logic [LEN_W-1:0] s;
  logic [LEN_W-1:0] ad_len_r;
  logic [LEN_W-1:0] msg_len_r;
  logic             decrypt_r;
  logic             done_r;

  phase_t           next_phase;
  src_t             src;
  logic             step_en;
  logic             data_ready;
  logic             ca;
  logic             cb;
  logic             tag_cap;
  logic             last_step;
  logic             start_ok;
  logic [LEN_W-1:0] data_len;
  logic [LEN_W-1:0] pad_idx;
  logic [LEN_W-1:0] phase_steps;
  logic [LEN_W-1:0] s_next;

  assign s_next   = s + STEP;
  assign start_ok = ((phase == PH_IDLE) || (phase == PH_DONE)) && start_in;

  // AD and MSG share one counter: s < len is the data part, s - len indexes the pad.
  always_comb begin
    step_en     = 1'b0;
    data_ready  = 1'b0;
    src         = SRC_KEY;
    ca          = 1'b0;
    cb          = 1'b0;
    tag_cap     = 1'b0;
    phase_steps = '0;
    next_phase  = PH_IDLE;
    data_len    = (phase == PH_AD) ? ad_len_r : msg_len_r;
    pad_idx     = s - data_len;
    case (phase)
      PH_INIT: begin
        step_en     = 1'b1;
        ca          = 1'b1;
        cb          = 1'b1;
        phase_steps = INIT_STEPS;
        next_phase  = PH_AD;
        if (s < KEY_END)     src = SRC_KEY;
        else if (s < IV_END) src = SRC_IV;
        else if (s == IV_END) src = SRC_KEY_FLIP;
        else                 src = SRC_KEY;
      end
      PH_AD, PH_MSG: begin
        cb          = (phase == PH_AD);
        phase_steps = data_len + PAD_STEPS;
        next_phase  = (phase == PH_AD) ? PH_MSG : PH_FINAL;
        if (s < data_len) begin
          data_ready = 1'b1;
          step_en    = data_valid_in;
          src        = SRC_DATA;
          ca         = 1'b1;
        end else begin
          step_en = 1'b1;
          src     = (pad_idx == '0) ? SRC_PAD1 : SRC_ZERO;
          ca      = (pad_idx < PAD_CA_END);
        end
      end
      PH_FINAL: begin
        step_en     = 1'b1;
        ca          = 1'b1;
        cb          = 1'b1;
        src         = SRC_ZERO;
        tag_cap     = (s >= TAG_FIRST);
        phase_steps = FINAL_STEPS;
        next_phase  = PH_DONE;
      end
      default: ;
    endcase
  end

  assign last_step = step_en && (s_next == phase_steps);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= PH_IDLE;
      s         <= '0;
      ad_len_r  <= '0;
      msg_len_r <= '0;
      decrypt_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort_in) begin
        phase     <= PH_IDLE;
        s         <= '0;
        ad_len_r  <= '0;
        msg_len_r <= '0;
        decrypt_r <= 1'b0;
      end else if (start_ok) begin
        phase     <= PH_INIT;
        s         <= '0;
        ad_len_r  <= ad_len_in & LEN_MASK;
        msg_len_r <= msg_len_in & LEN_MASK;
        decrypt_r <= decrypt_in;
      end else if (last_step) begin
        phase  <= next_phase;
        s      <= '0;
        done_r <= (next_phase == PH_DONE);
      end else if (step_en) begin
        s <= s_next;
      end
    end
  end

`ifdef ACORN_TAG_CHECK_EN
  logic [127:0] tag_r;
  logic         tag_bad;
  logic         tag_ok_r;
  logic         tag_mismatch;

  // FINAL step 640 is a multiple of 128, so s[6:0] is the tag bit index of the chunk.
  assign tag_mismatch = tag_cap && (ks_in != tag_r[s[6:0] +: P]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_r    <= '0;
      tag_bad  <= 1'b0;
      tag_ok_r <= 1'b0;
    end else if (abort_in) begin
      tag_bad  <= 1'b0;
      tag_ok_r <= 1'b0;
    end else if (start_ok) begin
      tag_r    <= tag_in;
      tag_bad  <= 1'b0;
      tag_ok_r <= 1'b0;
    end else begin
      if (tag_mismatch) tag_bad <= 1'b1;
      if (last_step && (phase == PH_FINAL))
        tag_ok_r <= decrypt_r && !tag_bad && !tag_mismatch;
    end
  end

  assign tag_ok_out = tag_ok_r;
`else
  assign tag_ok_out = 1'b0;
`endif

  assign data_ready_out = data_ready;
  assign step_en_out    = step_en;
  assign src_sel_out    = src;
  assign key_idx_out    = s[6:0];
  assign ca_out         = ca;
  assign cb_out         = cb;
  assign decrypt_out    = decrypt_r;
  assign phase_out      = phase;
  assign tag_cap_out    = tag_cap;
  assign busy_out       = (phase != PH_IDLE) && (phase != PH_DONE);
  assign done_out       = done_r;

endmodule
